// File: rtl/lvds_pkg.sv
// Shared constants and types for the LVDS line framer.
// Holds the sync word values, default line code words, the framer state
// enum and the pixel / pixel-count widths.
package lvds_pkg;

  localparam int unsigned DATA_W = 12;
  localparam int unsigned CNT_W  = 10;

  localparam logic [DATA_W-1:0] SYNC_ONES = 12'hFFF;
  localparam logic [DATA_W-1:0] SYNC_ZERO = 12'h000;

  localparam logic [DATA_W-1:0] SOL_DEFAULT = 12'h800;
  localparam logic [DATA_W-1:0] EOL_DEFAULT = 12'h9D0;

  localparam int unsigned MAX_PIXEL_DEFAULT = 64;

  // HUNT..S3 are walked by the sync detector; ACTIVE/DRAIN belong to the framer.
  typedef enum logic [2:0] {
    ST_HUNT   = 3'd0,
    ST_S1     = 3'd1,
    ST_S2     = 3'd2,
    ST_S3     = 3'd3,
    ST_ACTIVE = 3'd4,
    ST_DRAIN  = 3'd5
  } state_e;

endpackage

// File: rtl/lvds_sync_detect.sv
// Sync sequence hunter: FFF, 000, 000, <code>.
// Ports:
//   clk_i, rst_ni      clock, async active-low reset
//   word_i, valid_i    deserialized word and its accept strobe
//   busy_i             framer is in ACTIVE/DRAIN; only FFF is of interest
//   sync_ok_c_o        combinational: code word accepted after a full sync
//   sync_bad_c_o       combinational: sync sequence broken
//   code_c_o           combinational: the code word (valid with sync_ok_c_o)
module lvds_sync_detect
  import lvds_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] word_i,
  input  logic              valid_i,
  input  logic              busy_i,
  output logic              sync_ok_c_o,
  output logic              sync_bad_c_o,
  output logic [DATA_W-1:0] code_c_o
);

  state_e state_q, state_d;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_HUNT;
    else         state_q <= state_d;
  end

  // Next-state and report decode
  always_comb begin
    state_d      = state_q;
    sync_ok_c_o  = 1'b0;
    sync_bad_c_o = 1'b0;
    code_c_o     = word_i;
    if (valid_i) begin
      if (busy_i) begin
        // During a line FFF both ends it and starts the next sync.
        state_d = (word_i == SYNC_ONES) ? ST_S1 : ST_HUNT;
      end else begin
        case (state_q)
          ST_HUNT: begin
            if (word_i == SYNC_ONES) state_d = ST_S1;
          end
          ST_S1: begin
            if (word_i == SYNC_ZERO) state_d = ST_S2;
            else if (word_i == SYNC_ONES) state_d = ST_S1;
            else begin
              state_d      = ST_HUNT;
              sync_bad_c_o = 1'b1;
            end
          end
          ST_S2: begin
            if (word_i == SYNC_ZERO) state_d = ST_S3;
            else begin
              state_d      = ST_HUNT;
              sync_bad_c_o = 1'b1;
            end
          end
          ST_S3: begin
            state_d     = ST_HUNT;
            sync_ok_c_o = 1'b1;
          end
          default: state_d = ST_HUNT;
        endcase
      end
    end
  end

endmodule

// File: rtl/lvds_line_framer.sv
// Line framer: strips sync/code words from the deserialized stream and
// emits active pixels with a per-line index and a line-long write enable.
// Ports:
//   SDR_CLK, RST_N      clock, async active-low reset
//   Rx_data, Rx_valid   deserialized word, accept strobe (low = stall)
//   Pixel_data          registered active pixel
//   Pixel_count         registered index of Pixel_data within the line
//   Write_EN            registered, high for the whole active line
//   Line_done           pulse: line closed with exactly MAX_PIXEL pixels
//   Line_err            pulse: short line, or EOL after an overlong line
//   Sync_err            pulse: broken sync sequence
module lvds_line_framer
  import lvds_pkg::*;
#(
  parameter int unsigned       MAX_PIXEL = MAX_PIXEL_DEFAULT,
  parameter logic [DATA_W-1:0] SOL_CODE  = SOL_DEFAULT,
  parameter logic [DATA_W-1:0] EOL_CODE  = EOL_DEFAULT
) (
  input  logic              SDR_CLK,
  input  logic              RST_N,
  input  logic [DATA_W-1:0] Rx_data,
  input  logic              Rx_valid,
  output logic [DATA_W-1:0] Pixel_data,
  output logic [CNT_W-1:0]  Pixel_count,
  output logic              Write_EN,
  output logic              Line_done,
  output logic              Line_err,
  output logic              Sync_err
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_PIXEL - 1);

  state_e            mode_q, mode_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] pix_q, pix_d;
  logic [CNT_W-1:0]  pcnt_q, pcnt_d;
  logic              we_q, we_d;
  logic              done_q, done_d;
  logic              lerr_q, lerr_d;
  logic              serr_q, serr_d;
  logic              ovr_q, ovr_d;
  logic              done_pend_q, done_pend_d;

  logic              busy;
  logic              sync_ok_c;
  logic              sync_bad_c;
  logic [DATA_W-1:0] code_c;

  assign busy = (mode_q == ST_ACTIVE) || (mode_q == ST_DRAIN);

  lvds_sync_detect u_sync (
    .clk_i        (SDR_CLK),
    .rst_ni       (RST_N),
    .word_i       (Rx_data),
    .valid_i      (Rx_valid),
    .busy_i       (busy),
    .sync_ok_c_o  (sync_ok_c),
    .sync_bad_c_o (sync_bad_c),
    .code_c_o     (code_c)
  );

  // State and output registers
  always_ff @(posedge SDR_CLK or negedge RST_N) begin
    if (!RST_N) begin
      mode_q      <= ST_HUNT;
      cnt_q       <= '0;
      pix_q       <= '0;
      pcnt_q      <= '0;
      we_q        <= 1'b0;
      done_q      <= 1'b0;
      lerr_q      <= 1'b0;
      serr_q      <= 1'b0;
      ovr_q       <= 1'b0;
      done_pend_q <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      pix_q       <= pix_d;
      pcnt_q      <= pcnt_d;
      we_q        <= we_d;
      done_q      <= done_d;
      lerr_q      <= lerr_d;
      serr_q      <= serr_d;
      ovr_q       <= ovr_d;
      done_pend_q <= done_pend_d;
    end
  end

  // Framer next-state and output decode
  always_comb begin
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    pix_d       = pix_q;
    pcnt_d      = pcnt_q;
    we_d        = we_q;
    done_d      = 1'b0;
    lerr_d      = 1'b0;
    serr_d      = 1'b0;
    ovr_d       = ovr_q;
    done_pend_d = 1'b0;

    // Full line closes one cycle after its last pixel, stall or not.
    if (done_pend_q) begin
      we_d   = 1'b0;
      done_d = 1'b1;
    end

    if (Rx_valid) begin
      case (mode_q)
        ST_ACTIVE: begin
          if (Rx_data == SYNC_ONES) begin
            mode_d = ST_HUNT;
            we_d   = 1'b0;
            lerr_d = 1'b1;
          end else begin
            pix_d  = Rx_data;
            pcnt_d = cnt_q;
            we_d   = 1'b1;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_IDX) begin
              mode_d      = ST_DRAIN;
              done_pend_d = 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          // Any discarded word marks the line overlong for the closing EOL.
          if (Rx_data == SYNC_ONES) mode_d = ST_HUNT;
          else                      ovr_d  = 1'b1;
        end
        default: begin
          if (sync_bad_c) begin
            serr_d = 1'b1;
            ovr_d  = 1'b0;
          end
          if (sync_ok_c) begin
            ovr_d = 1'b0;
            if (code_c == SOL_CODE) begin
              mode_d = ST_ACTIVE;
              cnt_d  = '0;
            end else if (code_c == EOL_CODE) begin
              lerr_d = ovr_q;
            end else begin
              serr_d = 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign Pixel_data  = pix_q;
  assign Pixel_count = pcnt_q;
  assign Write_EN    = we_q;
  assign Line_done   = done_q;
  assign Line_err    = lerr_q;
  assign Sync_err    = serr_q;

endmodule
